// File: rtl/mul_pkg.sv
// ============================================================================
// Module   : mul_pkg
// Brief    : Shared types and helpers for the digit-serial multiply controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PP_W = 4;

  function automatic int digits(input int width);
    return width / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul2x2.sv
// ============================================================================
// Module   : mul2x2
// Brief    : Combinational 2-bit x 2-bit unsigned multiplier core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul2x2
  import mul_pkg::*;
(
  input  logic [1:0]      a,
  input  logic [1:0]      b,
  output logic [PP_W-1:0] p
);

  logic t01;
  logic t10;
  logic t11;

  assign t01 = a[0] & b[1];
  assign t10 = a[1] & b[0];
  assign t11 = a[1] & b[1];

  assign p[0] = a[0] & b[0];
  assign p[1] = t01 ^ t10;
  assign p[2] = (t01 & t10) ^ t11;
  assign p[3] = t01 & t10 & t11;

endmodule

`default_nettype wire

// File: rtl/mul_seq_ctrl.sv
// ============================================================================
// Module   : mul_seq_ctrl
// Brief    : Sequences one shared 2x2 multiplier over all digit pairs to form
//            a full WIDTH x WIDTH unsigned product, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int D     = digits(WIDTH);
  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(D - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;

  logic [1:0]         a_dig;
  logic [1:0]         b_dig;
  logic [PP_W-1:0]    pp;
  logic [IDX_W:0]     dig_sum;
  logic [ACC_W-1:0]   pp_shifted;

  assign a_dig      = 2'(a_q >> {i_q, 1'b0});
  assign b_dig      = 2'(b_q >> {j_q, 1'b0});
  assign dig_sum    = {1'b0, i_q} + {1'b0, j_q};
  assign pp_shifted = ACC_W'(pp) << {dig_sum, 1'b0};

  mul2x2 u_core (
    .a (a_dig),
    .b (b_dig),
    .p (pp)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + pp_shifted;
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d     = '0;
            state_d = DONE;
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
    end
  end

  // rst gates in_ready so nothing is offered while reset is held
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
// ============================================================================
// Module   : tb_mul_seq_ctrl
// Brief    : Self-checking bench for mul_seq_ctrl at WIDTH=8 and WIDTH=2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

  localparam int LAT8 = 16;

  logic        clk = 1'b0;
  logic        rst;

  logic        iv8, ir8, ov8, or8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;

  logic        iv2, ir2, ov2, or2, busy2;
  logic [1:0]  a2, b2;
  logic [3:0]  p2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_a(a8), .in_b(b8),
    .out_valid(ov8), .out_ready(or8), .out_p(p8), .busy(busy8)
  );

  mul_seq_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst),
    .in_valid(iv2), .in_ready(ir2), .in_a(a2), .in_b(b2),
    .out_valid(ov2), .out_ready(or2), .out_p(p2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One WIDTH=8 transaction; hold=0 means out_ready is tied high.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input int hold);
    int          k;
    logic [15:0] exp;
    exp = 16'(a) * 16'(b);
    check("idle_ready", ir8, 1);
    or8 = (hold == 0);
    iv8 = 1'b1;
    a8  = a;
    b8  = b;
    tick();
    iv8 = 1'b0;
    check("busy_run", busy8, 1);
    check("acc_cleared_valid", ov8, 0);
    k = 0;
    while (!ov8 && k < 100) begin
      iv8 = (k < LAT8 - 1) ? 1'($urandom % 2) : 1'b0;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      tick();
      iv8 = 1'b0;
      k++;
    end
    check("latency", k, LAT8);
    check("out_p", p8, exp);
    for (int h = 0; h < hold; h++) begin
      iv8 = 1'($urandom % 2);
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      tick();
      iv8 = 1'b0;
      check("hold_valid", ov8, 1);
      check("hold_p", p8, exp);
      check("hold_ready", ir8, 0);
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    check("post_valid", ov8, 0);
    check("post_ready", ir8, 1);
    check("post_busy", busy8, 0);
  endtask

  initial begin
    logic [3:0] q[$];
    int         acc_cyc[$];
    int         cyc;
    int         idx;
    int         got;
    int         seen;
    bit         prev_ov;
    bit         acc_now;
    bit         hs_now;

    rst = 1'b1;
    iv8 = 1'b1; a8 = 8'h5A; b8 = 8'hC3; or8 = 1'b0;
    iv2 = 1'b1; a2 = 2'd3;  b2 = 2'd3;  or2 = 1'b0;
    repeat (3) begin
      tick();
      check("rst_valid", ov8, 0);
      check("rst_busy", busy8, 0);
      check("rst_p", p8, 0);
      check("rst_ready", ir8, 0);
    end
    rst = 1'b0;
    iv8 = 1'b0;
    iv2 = 1'b0;
    #1;
    check("rel_ready8", ir8, 1);
    check("rel_ready2", ir2, 1);
    tick();
    check("rel_no_accept", busy8, 0);

    run8(8'hFF, 8'hFF, 0);
    run8(8'hA5, 8'h3C, 0);
    run8(8'h12, 8'h34, 5);

    // Abort partway through RUN, then confirm a clean restart.
    iv8 = 1'b1; a8 = 8'hFF; b8 = 8'h02;
    tick();
    iv8 = 1'b0;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    check("abort_ready_low", ir8, 0);
    tick();
    check("abort_valid", ov8, 0);
    check("abort_busy", busy8, 0);
    check("abort_p", p8, 0);
    rst = 1'b0;
    seen = 0;
    repeat (20) begin
      tick();
      if (ov8) seen++;
    end
    check("abort_no_pulse", seen, 0);
    run8(8'h03, 8'h07, 0);

    repeat (6) run8(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));

    // WIDTH=2: all 16 pairs streamed back-to-back against a FIFO of products.
    cyc = 0; idx = 0; got = 0; prev_ov = 1'b0;
    while (got < 16 && cyc < 400) begin
      if (idx < 16) begin
        iv2 = 1'b1;
        a2  = 2'(idx >> 2);
        b2  = 2'(idx);
      end else begin
        iv2 = 1'b0;
      end
      or2     = ($urandom % 4) != 0;
      acc_now = iv2 && ir2;
      hs_now  = ov2 && or2;
      if (ov2 && !prev_ov && acc_cyc.size() > 0)
        check("w2_latency", cyc - acc_cyc[0], 1);
      if (hs_now) begin
        if (q.size() == 0) begin
          check("w2_spurious", ov2, 0);
        end else begin
          check("w2_p", p2, q.pop_front());
          void'(acc_cyc.pop_front());
          got++;
        end
      end
      prev_ov = ov2;
      tick();
      cyc++;
      if (acc_now) begin
        q.push_back({2'b00, a2} * {2'b00, b2});
        acc_cyc.push_back(cyc);
        idx++;
      end
    end
    iv2 = 1'b0;
    check("w2_count", got, 16);
    check("w2_leftover", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
